// File: rtl/tb_stim_pkg.sv
// Shared types and constants for the stimulus sequencer.
// Also holds the Galois LFSR step shared by generator and top.
package tb_stim_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    RUN,
    GAP,
    DONE
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  localparam int CLK_T            = 10;
  localparam int DEF_RESET_CYCLES = 10;
  localparam int DEF_DATA_CYCLES  = 40;

  // Right-shift Galois form of x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    return s[0] ? ((s >> 1) ^ LFSR_POLY)
                : (s >> 1);
  endfunction

endpackage

// File: rtl/tb_stimulus_sequencer_lfsr.sv
// One 32-bit Galois LFSR channel generator.
// Load (reseed) has priority over advance.
module stim_lfsr32
  import tb_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= seed;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/tb_stimulus_sequencer.sv
// Timed DUT reset plus ramp/LFSR/constant burst generator
// with valid/ready flow control and fully registered outputs.
module tb_stimulus_sequencer
  import tb_stim_pkg::*;
#(
  parameter int          DATA_WIDTH   = 16,
  parameter int          NUM_CHANNELS = 4,
  parameter int          RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int          DATA_CYCLES  = DEF_DATA_CYCLES,
  parameter int          GAP_CYCLES   = 0,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [1:0]                           mode,
  input  logic [DATA_WIDTH-1:0]                const_value,
  input  logic                                 ready,
  output logic                                 dut_reset,
  output logic                                 busy,
  output logic                                 valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data,
  output logic                                 last,
  output logic                                 done,
  output logic [$clog2(DATA_CYCLES+1)-1:0]     beat_count
);

  localparam int DW = DATA_WIDTH;
  localparam int NC = NUM_CHANNELS;
  localparam int BW = $clog2(DATA_CYCLES+1);
  localparam int CNT_MAX =
    (RESET_CYCLES > GAP_CYCLES) ? RESET_CYCLES
                                : GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX+1);

  localparam logic [BW-1:0] LAST_IDX =
    BW'(DATA_CYCLES-1);
  localparam logic [CW-1:0] HOLD_END =
    CW'(RESET_CYCLES-1);
  localparam logic [CW-1:0] GAP_END =
    (GAP_CYCLES > 0) ? CW'(GAP_CYCLES-1) : '0;

  state_e              state;
  logic [CW-1:0]       cnt;
  logic [1:0]          mode_q;
  logic [DW-1:0]       const_q;
  logic [NC*32-1:0]    seeds;
  logic [NC*32-1:0]    lfsr_st;
  logic [NC*32-1:0]    lfsr_nx;
  logic [BW-1:0]       nxt_idx;
  logic                go;
  logic                accept;
  logic                final_beat;

  assign go         = (state == IDLE) && start;
  assign accept     = (state == RUN) && valid && ready;
  assign final_beat = (beat_count == LAST_IDX);
  assign nxt_idx    = beat_count + 1'b1;

  for (genvar c = 0; c < NC; c++) begin : g_ch
    assign seeds[c*32 +: 32] = LFSR_SEED + 32'(c);

    stim_lfsr32 u_lfsr (
      .clk     (clk),
      .rst_n   (reset),
      .seed    (seeds[c*32 +: 32]),
      .load    (go),
      .advance (accept),
      .state   (lfsr_st[c*32 +: 32])
    );

    assign lfsr_nx[c*32 +: 32] =
      lfsr_step(lfsr_st[c*32 +: 32]);
  end

  // Reserved mode 3 falls through to ramp
  function automatic logic [NC*DW-1:0] sample_f(
    input logic [1:0]       m,
    input logic [BW-1:0]    n,
    input logic [NC*32-1:0] lf,
    input logic [DW-1:0]    cv
  );
    logic [NC*DW-1:0] s;
    s = '0;
    for (int c = 0; c < NC; c++) begin
      case (mode_e'(m))
        MODE_LFSR:  s[c*DW +: DW] = lf[c*32 +: DW];
        MODE_CONST: s[c*DW +: DW] = cv;
        default:    s[c*DW +: DW] =
                      DW'(32'(n) + 32'(c));
      endcase
    end
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RST_HOLD;
      cnt        <= '0;
      dut_reset  <= 1'b1;
      busy       <= 1'b1;
      valid      <= 1'b0;
      last       <= 1'b0;
      done       <= 1'b0;
      data       <= '0;
      beat_count <= '0;
      mode_q     <= MODE_RAMP;
      const_q    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        RST_HOLD: begin
          if (cnt == HOLD_END) begin
            cnt       <= '0;
            dut_reset <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            const_q    <= const_value;
            beat_count <= '0;
            data       <= sample_f(mode, '0, seeds,
                                   const_value);
            last       <= (DATA_CYCLES == 1);
            valid      <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            beat_count <= nxt_idx;
            if (final_beat) begin
              valid <= 1'b0;
              last  <= 1'b0;
              cnt   <= '0;
              if (GAP_CYCLES > 0) begin
                state <= GAP;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              data <= sample_f(mode_q, nxt_idx,
                               lfsr_nx, const_q);
              last <= (nxt_idx == LAST_IDX);
            end
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            cnt   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_stimulus_sequencer.sv
// Directed bench for tb_stimulus_sequencer: scoreboard of
// expected beats, two instances (no gap / 3-cycle gap).
module tb_tb_stimulus_sequencer;
  import tb_stim_pkg::*;

  localparam int          DW   = 16;
  localparam int          NC   = 4;
  localparam int          RC   = 10;
  localparam int          DC   = 40;
  localparam int          GC   = 3;
  localparam logic [31:0] SEED = 32'hACE1;
  localparam int          BW   = $clog2(DC+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] const_value = '0;

  logic             dut_reset, busy, valid, last, done;
  logic [NC*DW-1:0] data;
  logic [BW-1:0]    beat_count;

  logic             g_dut_reset, g_busy, g_valid;
  logic             g_last, g_done;
  logic [NC*DW-1:0] g_data;
  logic [BW-1:0]    g_beat_count;

  int checks = 0;
  int errors = 0;
  logic [NC*DW:0] sb[$];

  always #(CLK_T/2) clk = ~clk;

  tb_stimulus_sequencer #(
    .DATA_WIDTH   (DW),
    .NUM_CHANNELS (NC),
    .RESET_CYCLES (RC),
    .DATA_CYCLES  (DC),
    .GAP_CYCLES   (0),
    .LFSR_SEED    (SEED)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .const_value (const_value),
    .ready       (ready),
    .dut_reset   (dut_reset),
    .busy        (busy),
    .valid       (valid),
    .data        (data),
    .last        (last),
    .done        (done),
    .beat_count  (beat_count)
  );

  tb_stimulus_sequencer #(
    .DATA_WIDTH   (DW),
    .NUM_CHANNELS (NC),
    .RESET_CYCLES (RC),
    .DATA_CYCLES  (DC),
    .GAP_CYCLES   (GC),
    .LFSR_SEED    (SEED)
  ) u_gap (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .const_value (const_value),
    .ready       (ready),
    .dut_reset   (g_dut_reset),
    .busy        (g_busy),
    .valid       (g_valid),
    .data        (g_data),
    .last        (g_last),
    .done        (g_done),
    .beat_count  (g_beat_count)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_lfsr(
    input logic [31:0] s
  );
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  task automatic push_expected(input logic [1:0] m,
                               input logic [DW-1:0] cv);
    logic [31:0]      lf[NC];
    logic [NC*DW-1:0] w;
    for (int c = 0; c < NC; c++) lf[c] = SEED + 32'(c);
    for (int n = 0; n < DC; n++) begin
      w = '0;
      for (int c = 0; c < NC; c++) begin
        case (m)
          2'd1:    w[c*DW +: DW] = lf[c][DW-1:0];
          2'd2:    w[c*DW +: DW] = cv;
          default: w[c*DW +: DW] = DW'(n + c);
        endcase
        lf[c] = ref_lfsr(lf[c]);
      end
      sb.push_back({(n == DC-1), w});
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((busy || g_busy) && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (b >= 200)
      check("idle_timeout", {62'b0, busy, g_busy}, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= RC; i++) begin
      @(posedge clk);
      #1;
      if (i < RC) begin
        check("hold", {dut_reset, busy}, 2'b11);
      end else begin
        check("rel", {dut_reset, busy}, 2'b00);
        check("rel_gap", {g_dut_reset, g_busy}, 2'b00);
      end
      check("hold_valid", {valid, g_valid}, 2'b00);
    end
  endtask

  task automatic run_burst(input logic [1:0]    m,
                           input logic [DW-1:0] cv,
                           input int            pat,
                           input bit            poke,
                           input int            abort_at);
    int             acc;
    int             k;
    logic           r;
    logic [NC*DW:0] e;
    acc = 0;
    k = 0;
    wait_idle();
    push_expected(m, cv);
    start = 1'b1;
    mode = m;
    const_value = cv;
    @(negedge clk);
    start = 1'b0;
    mode = 2'd3;
    const_value = ~cv;
    check("start_busy", {busy, valid}, 2'b11);
    while (acc < DC && k < 600) begin
      if (abort_at > 0 && acc == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_out",
              {dut_reset, busy, valid, last, done},
              5'b11000);
        check("abort_data", data, 0);
        check("abort_cnt", beat_count, 0);
        sb.delete();
        return;
      end
      e = sb[0];
      check("run_valid", {valid, g_valid}, 2'b11);
      check("beat_data", data, e[NC*DW-1:0]);
      check("beat_last", last, e[NC*DW]);
      check("gap_inst_data", g_data, e[NC*DW-1:0]);
      check("beat_idx", beat_count, acc);
      r = (pat == 0) ? 1'b1 : (k % 4 == 0 || k % 4 == 3);
      ready = r;
      start = poke && (acc == 10);
      if (r) begin
        if (m == 2'd0 && acc == 5)
          check("ramp_c2_b5", data[2*DW +: DW], 7);
        if (m == 2'd1 && acc == 0)
          check("lfsr_c0_b0", data[DW-1:0], 16'hACE1);
        void'(sb.pop_front());
        acc++;
      end
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b0;
    if (k >= 600) check("burst_timeout", acc, DC);
    check("done_pulse", {done, valid, busy}, 3'b101);
    check("final_count", beat_count, DC);
    for (int i = 1; i <= GC; i++) begin
      check("gap_idle", {g_valid, g_done, g_busy}, 3'b001);
      @(negedge clk);
      if (i == 1) check("done_once", {done, busy}, 2'b00);
    end
    check("gap_done",
          {g_done, g_valid, g_beat_count == BW'(DC)},
          3'b101);
    @(negedge clk);
    check("gap_idle_after", {g_done, g_busy}, 2'b00);
  endtask

  initial begin
    #(CLK_T*20000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_flags",
          {dut_reset, busy, valid, last, done},
          5'b11000);
    check("rst_data", data, 0);
    check("rst_cnt", beat_count, 0);
    check("rst_gap_flags",
          {g_dut_reset, g_busy, g_valid}, 3'b110);

    release_reset();
    @(negedge clk);

    run_burst(2'd0, '0, 0, 1'b0, 0);
    run_burst(2'd0, '0, 1, 1'b0, 0);
    run_burst(2'd1, '0, 0, 1'b0, 0);
    run_burst(2'd1, '0, 1, 1'b0, 0);
    run_burst(2'd2, 16'h1234, 0, 1'b1, 0);
    run_burst(2'd3, '0, 0, 1'b0, 0);
    run_burst(2'd0, '0, 0, 1'b0, 20);

    release_reset();
    @(negedge clk);
    run_burst(2'd0, '0, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_stimulus_sequencer.md
Name: tb_stimulus_sequencer

Overview:
- Parametrised, synthesisable stimulus sequencer; the next generation of the fixed-constant test settings (clock period, reset time, data cycles).
- Generates a timed DUT reset, then on command emits bursts of DATA_CYCLES multi-channel samples under valid/ready flow control.
- Sits between the bench/top-level controller and the convolution datapath input, for simulation and FPGA self-test.

Parameters:
- DATA_WIDTH, 16, bits per channel sample (1..32).
- NUM_CHANNELS, 4, parallel channels per beat (>=1).
- RESET_CYCLES, 10, clocks dut_reset stays high after reset release (>=1).
- DATA_CYCLES, 40, beats per burst (>=1).
- GAP_CYCLES, 0, idle clocks after last beat before done (>=0).
- LFSR_SEED, 32'hACE1, base LFSR seed; channel c uses LFSR_SEED + c (must be nonzero per channel).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  burst request, sampled in IDLE only.
- mode  in  2  0=ramp, 1=LFSR, 2=constant, 3=reserved (treated as ramp); latched at accepted start.
- const_value  in  DATA_WIDTH  constant-mode sample; latched at accepted start.
- ready  in  1  downstream accept.
- dut_reset  out  1  active-high reset to DUT.
- busy  out  1  high outside IDLE.
- valid  out  1  beat valid.
- data  out  NUM_CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- last  out  1  high with final beat of burst.
- done  out  1  one-cycle pulse at burst end.
- beat_count  out  $clog2(DATA_CYCLES+1)  beats accepted in current burst.

Behaviour:
- Reset asserted (low): dut_reset=1, busy=1, valid=0, last=0, done=0, data=0, beat_count=0, state=RST_HOLD, hold counter=0, LFSRs reseeded. Applies immediately, including mid-burst; any burst in progress is discarded.
- RST_HOLD: counts clocks after reset release. dut_reset drops on the clock edge after RESET_CYCLES edges, then state=IDLE.
- IDLE: busy=0, valid=0. start=1 latches mode and const_value, clears beat_count, enters RUN. valid=1 with beat 0 on the next cycle. start outside IDLE is ignored.
- RUN: valid=1. data/last are held stable while ready=0. A beat is accepted when valid&&ready; on acceptance beat_count increments and the next sample is presented the following cycle with no bubble.
  - last=1 exactly when beat index = DATA_CYCLES-1.
  - After the last beat is accepted: GAP_CYCLES>0 goes to GAP, otherwise DONE.
- GAP: valid=0, counts GAP_CYCLES clocks, then DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE. beat_count holds its final value until the next start.
- Sample n (beat index), channel c:
  - ramp: (n + c) mod 2^DATA_WIDTH.
  - LFSR: low DATA_WIDTH bits of channel-c 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1. Seeded LFSR_SEED+c at reset and at each accepted start; advances once per accepted beat. Beat 0 = seed.
  - constant: latched const_value on all channels.
- DATA_CYCLES=1: the single beat carries last=1. ready held low indefinitely: design stalls, no timeout.
- Outputs are registered; no combinational path from ready to valid.

Decomposition:
- Shared package tb_stim_pkg holds:
  - mode enum (MODE_RAMP, MODE_LFSR, MODE_CONST).
  - state enum (RST_HOLD, IDLE, RUN, GAP, DONE).
  - LFSR_POLY constant 32'h80200003.
  - defaults for CLK_T/RESET_CYCLES/DATA_CYCLES.
- One sub-module, stim_lfsr32: seed, load, advance inputs; state output. Instantiated NUM_CHANNELS times via generate.

Test Plan:
- Reset release with RESET_CYCLES=10 -> dut_reset high for exactly 10 rising edges after reset high, then 0; busy falls the same cycle; valid stays 0.
- Ramp burst, ready=1, defaults -> 40 consecutive beats; channel 2 beat 5 = 7; last only on beat 39; done pulse the next cycle; beat_count=40.
- Backpressure: ready toggled 1,0,0,1 repeatedly in ramp mode -> data/last stable while stalled; no skipped or duplicated beat indices; 40 beats total.
- LFSR mode, two consecutive bursts -> beat 0 of each burst channel 0 = 32'hACE1 low 16 bits; sequence matches reference model, identical across bursts.
- Constant mode const_value=16'h1234, GAP_CYCLES=3 -> all channels 16'h1234; valid low 3 cycles after last; then done; start during RUN is ignored.
- Reset asserted at beat 20 -> valid=0 and dut_reset=1 the same cycle asynchronously; after release, 10-cycle hold, then IDLE; next burst starts at beat 0.
